v_counters_updown_mod: RTL and testbench
========================================

// Module: v_counters_updown_mod
// PURPOSE
//  Parametrised up/down counter with run-time modulus, parallel load, count enable,
//  and wrap or saturate behaviour at the limits. Flags limit events for cascading and
//  for software polling. Next generation of the fixed 4-bit up/down counter. Used
//  wherever a timer, address or tick counter needs a programmable range.
// PARAMETERS
//  WIDTH      8   counter width in bits (>=2)
//  SATURATE   0   0 = wrap at limits (modulo MAX+1); 1 = hold at limits
//  RESET_VAL  0   value of Q after reset (WIDTH bits)
// PORTS
//  C        in   1      clock; all state changes on rising edge
//  CLR_N    in   1      reset, synchronous, active-low
//  CE       in   1      count enable
//  UP_DOWN  in   1      1 = count up, 0 = count down
//  LOAD     in   1      parallel load strobe
//  D        in   WIDTH  parallel load value
//  MAX      in   WIDTH  upper count limit (inclusive), sampled every cycle
//  OVF_CLR  in   1      clears sticky OVF
//  Q        out  WIDTH  counter value (registered)
//  TC       out  1      terminal count, combinational: CE & (UP_DOWN ? Q>=MAX : Q==0)
//  EVT      out  1      registered 1-cycle pulse: a limit event occurred last edge
//  OVF      out  1      sticky limit-event flag (registered)
// BEHAVIOUR
//  - One clock, C. Reset is synchronous and active-low on CLR_N.
//  - CLR_N=0 at an edge: Q<=RESET_VAL, EVT<=0, OVF<=0. Overrides every other input.
//  - Priority per edge: CLR_N low > LOAD > CE. With CE=0 and LOAD=0, Q holds.
//  - LOAD=1: Q<=D, unclamped even if D>MAX. EVT<=0. OVF unchanged except by OVF_CLR.
//  - Limit event = CE & !LOAD & TC (up with Q>=MAX, or down with Q==0).
//  - Count up, no event: Q<=Q+1.
//    Event with SATURATE=0: Q<=0. With SATURATE=1: Q<=MAX (Q>MAX is pulled to MAX).
//  - Count down, no event: Q<=Q-1 (Q>MAX decrements normally).
//    Event with SATURATE=0: Q<=MAX. With SATURATE=1: Q<=0 (holds).
//  - EVT<=limit event, every cycle. In saturate mode EVT stays 1 each enabled cycle
//    while the counter is pinned at a limit.
//  - OVF: set on limit event, cleared when OVF_CLR=1. Set and clear in the same cycle:
//    set wins (OVF=1).
//  - MAX=0: up from 0 is an event each enabled cycle (Q stays 0). Down behaves the same.
//  - MAX=2^WIDTH-1: full natural range; up wrap all-ones->0, down 0->all-ones.
//  - MAX may change at any time. The new value takes effect at the next edge; no
//    pipelining.
//  - Latency: Q, EVT and OVF update one edge after inputs. TC has zero latency (comb).
//  - Widths: all arithmetic is WIDTH bits, unsigned; no carry bit is kept in Q.
//  - Reset mid-count: the next edge gives Q=RESET_VAL and both flags 0, regardless
//    of CE/LOAD.
// STRUCTURE
//  - Shared package: no typedefs needed. SATURATE encoding constants (WRAP=0, SAT=1)
//    live in the common counters include, shared with the other counter blocks.
//  - One sub-module: v_counters_next_val (combinational).
//    Inputs: Q, MAX, UP_DOWN, CE, LOAD, D. Outputs: next Q, limit event.
//    Top level = registers for Q/EVT/OVF + CLR_N muxing + TC assign.
// TESTING
//  1 WIDTH=8, SAT=0, MAX=9, up from 0, 12 enabled cycles
//    -> Q 1..9,0,1,2; EVT high only the cycle after 9->0; OVF=1.
//  2 SAT=0, MAX=9, Q=0, down 2 cycles
//    -> Q=9 then 8; TC=1 only while Q==0; EVT pulse once.
//  3 SAT=1, MAX=5, up 8 cycles from 3
//    -> Q 4,5,5,5...; EVT=1 on each pinned cycle; down from 0 holds 0.
//  4 LOAD with D=200, MAX=100, then up 1 cycle
//    -> load: Q=200, EVT=0; next: wrap Q=0 (SAT=0) / Q=100 (SAT=1).
//  5 LOAD, CE and CLR_N=0 in the same cycle
//    -> Q=RESET_VAL, EVT=0, OVF=0. OVF_CLR together with an event -> OVF stays 1.
//  6 MAX=0 and MAX=255, up/down across the boundary
//    -> Q stays 0 with EVT each cycle; 255->0 and 0->255 with EVT pulse.

Source files
------------

// File: rtl/v_counters_pkg.sv
// rtl/v_counters_pkg.sv - shared constants for the counter family
package v_counters_pkg;

    // Limit behaviour encodings for the SATURATE parameter
    localparam int WRAP = 0;
    localparam int SAT  = 1;

    // True when the saturate encoding is selected
    function automatic bit is_saturating(input int mode);
        return (mode == SAT);
    endfunction

endpackage

// File: rtl/v_counters_updown_mod_next_val.sv
// rtl/v_counters_updown_mod_next_val.sv - combinational next-value and limit-event logic
module v_counters_next_val
    import v_counters_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = WRAP
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] max_i,
    input  logic             up_down_i,
    input  logic             ce_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_next_o,
    output logic             limit_evt_o
);

    logic at_limit;

    // Next count value with load priority, then enabled count with wrap or saturate
    always_comb begin
        at_limit    = up_down_i ? (q_i >= max_i) : (q_i == '0);
        limit_evt_o = ce_i & ~load_i & at_limit;
        q_next_o    = q_i;
        if (load_i) begin
            // Load is deliberately unclamped: D above MAX is accepted as-is
            q_next_o = d_i;
        end else if (ce_i) begin
            if (up_down_i) begin
                if (at_limit) begin
                    q_next_o = is_saturating(SATURATE) ? max_i : '0;
                end else begin
                    q_next_o = q_i + 1'b1;
                end
            end else begin
                if (at_limit) begin
                    q_next_o = is_saturating(SATURATE) ? '0 : max_i;
                end else begin
                    q_next_o = q_i - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/v_counters_updown_mod.sv
// rtl/v_counters_updown_mod.sv - up/down counter with run-time modulus, load and limit flags
module v_counters_updown_mod
    import v_counters_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               SATURATE  = WRAP,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             c_i,
    input  logic             clr_n_i,
    input  logic             ce_i,
    input  logic             up_down_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] max_i,
    input  logic             ovf_clr_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o,
    output logic             evt_o,
    output logic             ovf_o
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             evt_q, evt_d;
    logic             ovf_q, ovf_d;

    v_counters_next_val #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_next_val (
        .q_i         (q_q),
        .max_i       (max_i),
        .up_down_i   (up_down_i),
        .ce_i        (ce_i),
        .load_i      (load_i),
        .d_i         (d_i),
        .q_next_o    (q_d),
        .limit_evt_o (evt_d)
    );

    // Sticky overflow: a new event wins over a simultaneous clear
    always_comb begin
        ovf_d = evt_d | (ovf_q & ~ovf_clr_i);
    end

    // State registers with synchronous active-low clear overriding everything
    always_ff @(posedge c_i) begin
        if (!clr_n_i) begin
            q_q   <= RESET_VAL;
            evt_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            evt_q <= evt_d;
            ovf_q <= ovf_d;
        end
    end

    assign tc_o  = ce_i & (up_down_i ? (q_q >= max_i) : (q_q == '0));
    assign q_o   = q_q;
    assign evt_o = evt_q;
    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_v_counters_updown_mod.sv
// tb/tb_v_counters_updown_mod.sv - scoreboard bench for wrap and saturate counter instances
module tb_v_counters_updown_mod;

    typedef struct {
        int         cyc;
        int         u;
        int         sid;
        bit         is_tc;
        logic [7:0] q;
        logic       evt;
        logic       ovf;
        logic       tc;
    } item_t;

    logic       c = 1'b0;
    logic [1:0] clr_n, ce, ud, ld, oc;
    logic [7:0] d[2];
    logic [7:0] mx[2];
    logic [7:0] qv[2];
    logic [1:0] tcv, evtv, ovfv;

    item_t sb[$];
    item_t it;
    int    cyc = 0;
    int    sid = 0;
    int    passed = 0;
    int    total = 0;

    always #5 c = ~c;
    always @(posedge c) cyc <= cyc + 1;

    v_counters_updown_mod #(.WIDTH(8), .SATURATE(0), .RESET_VAL(8'd0)) u_wrap (
        .c_i(c), .clr_n_i(clr_n[0]), .ce_i(ce[0]), .up_down_i(ud[0]), .load_i(ld[0]),
        .d_i(d[0]), .max_i(mx[0]), .ovf_clr_i(oc[0]),
        .q_o(qv[0]), .tc_o(tcv[0]), .evt_o(evtv[0]), .ovf_o(ovfv[0])
    );

    v_counters_updown_mod #(.WIDTH(8), .SATURATE(1), .RESET_VAL(8'd3)) u_sat (
        .c_i(c), .clr_n_i(clr_n[1]), .ce_i(ce[1]), .up_down_i(ud[1]), .load_i(ld[1]),
        .d_i(d[1]), .max_i(mx[1]), .ovf_clr_i(oc[1]),
        .q_o(qv[1]), .tc_o(tcv[1]), .evt_o(evtv[1]), .ovf_o(ovfv[1])
    );

    task automatic check(input string nm, input int s, input int u,
                         input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s step%0d u%0d got %0h exp %0h", nm, s, u, got, exp);
    endtask

    // Monitor: pops every expectation whose cycle has been reached
    always @(negedge c) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            if (it.is_tc) begin
                check("tc", it.sid, it.u, {7'd0, tcv[it.u]}, {7'd0, it.tc});
            end else begin
                check("q",   it.sid, it.u, qv[it.u], it.q);
                check("evt", it.sid, it.u, {7'd0, evtv[it.u]}, {7'd0, it.evt});
                check("ovf", it.sid, it.u, {7'd0, ovfv[it.u]}, {7'd0, it.ovf});
            end
        end
    end

    // Apply one cycle of inputs; expect TC now and Q/EVT/OVF after the next edge
    task automatic step(input int u, input bit cl, input bit ce_, input bit ud_, input bit ld_,
                        input logic [7:0] dd, input logic [7:0] mm, input bit oc_,
                        input bit etc, input logic [7:0] eq, input bit eevt, input bit eovf);
        clr_n[u] = cl; ce[u] = ce_; ud[u] = ud_; ld[u] = ld_;
        d[u] = dd; mx[u] = mm; oc[u] = oc_;
        sid++;
        sb.push_back('{cyc, u, sid, 1'b1, 8'd0, 1'b0, 1'b0, etc});
        sb.push_back('{cyc + 1, u, sid, 1'b0, eq, eevt, eovf, 1'b0});
        @(posedge c);
        #1;
    endtask

    initial begin
        int qb;
        int wait_cnt;
        clr_n = 2'b00; ce = 2'b00; ud = 2'b11; ld = 2'b00; oc = 2'b00;
        d[0] = 8'd0; d[1] = 8'd0; mx[0] = 8'd9; mx[1] = 8'd5;
        repeat (2) @(posedge c);
        #1;

        // Wrapping instance, RESET_VAL=0
        step(0, 0, 0, 1, 0, 8'd0, 8'd9, 0, 0, 8'd0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            qb = (i < 10) ? i : i - 10;
            step(0, 1, 1, 1, 0, 8'd0, 8'd9, 0, qb == 9, 8'((qb + 1) % 10), qb == 9, i >= 9);
        end
        step(0, 1, 0, 1, 1, 8'd0,   8'd9,   0, 0, 8'd0,   0, 1);
        step(0, 1, 0, 0, 0, 8'd0,   8'd9,   1, 0, 8'd0,   0, 0);
        step(0, 1, 1, 0, 0, 8'd0,   8'd9,   0, 1, 8'd9,   1, 1);
        step(0, 1, 1, 0, 0, 8'd0,   8'd9,   0, 0, 8'd8,   0, 1);
        step(0, 1, 0, 1, 1, 8'd9,   8'd9,   0, 0, 8'd9,   0, 1);
        step(0, 1, 1, 1, 0, 8'd0,   8'd9,   1, 1, 8'd0,   1, 1);
        step(0, 1, 0, 1, 0, 8'd0,   8'd9,   1, 0, 8'd0,   0, 0);
        step(0, 1, 0, 1, 1, 8'd200, 8'd100, 0, 0, 8'd200, 0, 0);
        step(0, 1, 1, 1, 0, 8'd0,   8'd100, 0, 1, 8'd0,   1, 1);
        step(0, 1, 0, 1, 1, 8'd200, 8'd100, 0, 0, 8'd200, 0, 1);
        step(0, 1, 1, 0, 0, 8'd0,   8'd100, 0, 0, 8'd199, 0, 1);
        step(0, 1, 1, 1, 1, 8'd0,   8'd100, 0, 1, 8'd0,   0, 1);
        step(0, 1, 1, 1, 0, 8'd0,   8'd0,   0, 1, 8'd0,   1, 1);
        step(0, 1, 1, 1, 0, 8'd0,   8'd0,   0, 1, 8'd0,   1, 1);
        step(0, 1, 1, 0, 0, 8'd0,   8'd0,   0, 1, 8'd0,   1, 1);
        step(0, 1, 0, 1, 1, 8'd255, 8'd255, 0, 0, 8'd255, 0, 1);
        step(0, 1, 1, 1, 0, 8'd0,   8'd255, 0, 1, 8'd0,   1, 1);
        step(0, 1, 1, 0, 0, 8'd0,   8'd255, 0, 1, 8'd255, 1, 1);
        step(0, 1, 1, 0, 0, 8'd0,   8'd255, 0, 0, 8'd254, 0, 1);
        step(0, 0, 1, 1, 1, 8'd77,  8'd255, 0, 0, 8'd0,   0, 0);
        step(0, 1, 0, 1, 0, 8'd0,   8'd255, 0, 0, 8'd0,   0, 0);

        // Saturating instance, RESET_VAL=3
        step(1, 0, 0, 1, 0, 8'd0, 8'd5, 0, 0, 8'd3, 0, 0);
        for (int i = 0; i < 8; i++) begin
            qb = (3 + i > 5) ? 5 : 3 + i;
            step(1, 1, 1, 1, 0, 8'd0, 8'd5, 0, qb == 5, 8'((4 + i > 5) ? 5 : 4 + i), qb == 5, i >= 2);
        end
        step(1, 1, 0, 0, 1, 8'd0,   8'd5,   0, 0, 8'd0,   0, 1);
        step(1, 1, 1, 0, 0, 8'd0,   8'd5,   0, 1, 8'd0,   1, 1);
        step(1, 1, 1, 0, 0, 8'd0,   8'd5,   0, 1, 8'd0,   1, 1);
        step(1, 1, 0, 0, 0, 8'd0,   8'd5,   1, 0, 8'd0,   0, 0);
        step(1, 1, 0, 1, 1, 8'd200, 8'd100, 0, 0, 8'd200, 0, 0);
        step(1, 1, 1, 1, 0, 8'd0,   8'd100, 0, 1, 8'd100, 1, 1);
        step(1, 1, 1, 1, 0, 8'd0,   8'd100, 0, 1, 8'd100, 1, 1);
        step(1, 1, 0, 1, 1, 8'd200, 8'd100, 0, 0, 8'd200, 0, 1);
        step(1, 1, 1, 0, 0, 8'd0,   8'd100, 0, 0, 8'd199, 0, 1);
        step(1, 1, 1, 1, 0, 8'd0,   8'd0,   0, 1, 8'd0,   1, 1);
        step(1, 1, 1, 1, 0, 8'd0,   8'd0,   0, 1, 8'd0,   1, 1);
        step(1, 1, 0, 1, 1, 8'd255, 8'd255, 0, 0, 8'd255, 0, 1);
        step(1, 1, 1, 1, 0, 8'd0,   8'd255, 0, 1, 8'd255, 1, 1);
        step(1, 1, 0, 0, 1, 8'd0,   8'd255, 0, 0, 8'd0,   0, 1);
        step(1, 1, 1, 0, 0, 8'd0,   8'd255, 0, 1, 8'd0,   1, 1);
        step(1, 0, 1, 0, 1, 8'd9,   8'd255, 0, 1, 8'd3,   0, 0);

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 20) begin
            @(posedge c);
            wait_cnt++;
        end
        if (sb.size() > 0) begin
            total++;
            $display("FAIL drain pending %0d exp 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
